mcu_uart_rx: RTL and testbench

- UART receiver that consumes the MCU serial output `mcu_txd0` from `mcu_hq_top`: 8N1, LSB first.
- Deserialises frames and buffers bytes in a small first-word-fall-through (FWFT) FIFO for a host-side consumer (debug/log capture, or a bench scoreboard).
- Flags framing errors and overruns with sticky bits.
- Single clock domain on `sys_clk`; `rxd` is asynchronous to it and is synchronised internally.

---
 rtl/mcu_uart_rx.sv | 163 ++++++++++++++++
 tb/tb_mcu_uart_rx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_uart_rx.sv
// 8N1 UART receiver for the MCU debug serial line, with a small first-word-fall-through
// byte FIFO and sticky framing-error / overrun flags.
module mcu_uart_rx #(
   parameter int unsigned BAUD_DIV   = 434,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 3
) (
   input  logic             sys_clk,
   input  logic             io_resetb,
   input  logic             rxd,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [CNT_W-1:0] fifo_cnt,
   output logic             frame_err,
   output logic             overrun,
   input  logic             err_clr
);

   localparam int unsigned BW = $clog2(BAUD_DIV);
   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t          state, state_n;
   logic [BW-1:0]   bcnt, bcnt_n;
   logic [2:0]      bit_idx, bit_idx_n;
   logic [7:0]      shreg, shreg_n;
   logic            rxd_m, rxd_s;
   logic            sample, push, ferr_set;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0] cnt_n;
   logic            pop, full, wr_en, ovr_set;

   // Two-flop synchroniser; idles high so reset looks like a quiet line
   always_ff @(posedge sys_clk or negedge io_resetb) begin
      if (!io_resetb) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         rxd_m <= rxd;
         rxd_s <= rxd_m;
      end
   end

   always_ff @(posedge sys_clk or negedge io_resetb) begin
      if (!io_resetb) begin
         state   <= S_IDLE;
         bcnt    <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_n;
         bcnt    <= bcnt_n;
         bit_idx <= bit_idx_n;
         shreg   <= shreg_n;
      end
   end

   assign sample = (bcnt == '0);

   // Frame sequencing: half-bit delay to the start-bit centre, then whole-bit steps
   always_comb begin
      state_n   = state;
      bcnt_n    = bcnt;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      push      = 1'b0;
      ferr_set  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rxd_s) begin
               bcnt_n  = BW'(BAUD_DIV / 2 - 1);
               state_n = S_START;
            end
         end
         S_START: begin
            if (!sample) begin
               bcnt_n = bcnt - BW'(1);
            end else if (rxd_s) begin
               state_n = S_IDLE;
            end else begin
               bcnt_n    = BW'(BAUD_DIV - 1);
               bit_idx_n = '0;
               state_n   = S_DATA;
            end
         end
         S_DATA: begin
            if (!sample) begin
               bcnt_n = bcnt - BW'(1);
            end else begin
               shreg_n[bit_idx] = rxd_s;
               bcnt_n           = BW'(BAUD_DIV - 1);
               if (bit_idx == 3'd7) state_n = S_STOP;
               else                 bit_idx_n = bit_idx + 3'd1;
            end
         end
         S_STOP: begin
            if (!sample) begin
               bcnt_n = bcnt - BW'(1);
            end else if (rxd_s) begin
               push    = 1'b1;
               state_n = S_IDLE;
            end else begin
               ferr_set = 1'b1;
               state_n  = S_BREAK;
            end
         end
         S_BREAK: begin
            if (rxd_s) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // A full FIFO still accepts a byte when the consumer pops on the same edge
   assign pop     = rx_valid & rx_ready;
   assign full    = (fifo_cnt == CNT_W'(FIFO_DEPTH));
   assign wr_en   = push & (~full | pop);
   assign ovr_set = push & full & ~pop;

   always_comb begin
      cnt_n = fifo_cnt;
      case ({wr_en, pop})
         2'b10:   cnt_n = fifo_cnt + CNT_W'(1);
         2'b01:   cnt_n = fifo_cnt - CNT_W'(1);
         default: cnt_n = fifo_cnt;
      endcase
   end

   always_ff @(posedge sys_clk or negedge io_resetb) begin
      if (!io_resetb) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifo_cnt  <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         fifo_cnt  <= cnt_n;
         rx_valid  <= (cnt_n != '0);
         frame_err <= ferr_set | (frame_err & ~err_clr);
         overrun   <= ovr_set  | (overrun   & ~err_clr);
      end
   end

   assign rx_data = mem[rd_ptr];

endmodule

// File: tb/tb_mcu_uart_rx.sv
// Directed bench for mcu_uart_rx at BAUD_DIV=8: single byte, glitch rejection,
// framing error with break, overrun, full-with-pop, and reset mid-frame.
module tb_mcu_uart_rx;

   localparam int unsigned BAUD  = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = 3;

   logic          sys_clk = 1'b0;
   logic          io_resetb;
   logic          rxd;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [CW-1:0] fifo_cnt;
   logic          frame_err;
   logic          overrun;
   logic          err_clr;

   int checks   = 0;
   int failures = 0;

   mcu_uart_rx #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .sys_clk  (sys_clk),
      .io_resetb(io_resetb),
      .rxd      (rxd),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .fifo_cnt (fifo_cnt),
      .frame_err(frame_err),
      .overrun  (overrun),
      .err_clr  (err_clr)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic hold_bit(input logic v);
      rxd = v;
      repeat (BAUD) tick();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      hold_bit(1'b0);
      for (int i = 0; i < 8; i++) hold_bit(d[i]);
      hold_bit(stop);
   endtask

   task automatic do_pop();
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
   endtask

   task automatic test_reset();
      io_resetb = 1'b0;
      rxd = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
      repeat (3) tick();
      checks++;
      if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
      checks++;
      if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_data); end
      checks++;
      if (fifo_cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", fifo_cnt); end
      checks++;
      if (frame_err !== 1'b0 || overrun !== 1'b0) begin
         failures++; $display("FAIL reset_flags got=%b%b exp=00", frame_err, overrun);
      end
      io_resetb = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_single_byte();
      send_frame(8'h55, 1'b1);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h55 || fifo_cnt !== 3'd1) begin
         failures++;
         $display("FAIL single_rx got v=%b d=%h c=%0d exp v=1 d=55 c=1", rx_valid, rx_data, fifo_cnt);
      end
      do_pop();
      checks++;
      if (rx_valid !== 1'b0 || fifo_cnt !== 3'd0) begin
         failures++; $display("FAIL single_pop got v=%b c=%0d exp v=0 c=0", rx_valid, fifo_cnt);
      end
   endtask

   task automatic test_glitch();
      int bad = 0;
      rxd = 1'b0;
      repeat (2) tick();
      rxd = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rx_valid !== 1'b0 || frame_err !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL glitch_quiet got bad_cycles=%0d exp=0", bad); end
      send_frame(8'h5A, 1'b1);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin
         failures++; $display("FAIL glitch_next got v=%b d=%h exp v=1 d=5a", rx_valid, rx_data);
      end
      do_pop();
   endtask

   task automatic test_framing();
      send_frame(8'hA3, 1'b0);
      rxd = 1'b0;
      repeat (30) tick();
      hold_bit(1'b1);
      checks++;
      if (frame_err !== 1'b1 || fifo_cnt !== 3'd0 || rx_valid !== 1'b0) begin
         failures++;
         $display("FAIL frame_err got fe=%b c=%0d v=%b exp fe=1 c=0 v=0", frame_err, fifo_cnt, rx_valid);
      end
      send_frame(8'h3C, 1'b1);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h3C || fifo_cnt !== 3'd1) begin
         failures++;
         $display("FAIL frame_next got v=%b d=%h c=%0d exp v=1 d=3c c=1", rx_valid, rx_data, fifo_cnt);
      end
      do_pop();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++;
      if (frame_err !== 1'b0) begin failures++; $display("FAIL frame_clr got=%b exp=0", frame_err); end
   endtask

   task automatic test_overrun();
      logic [7:0] exp [4];
      exp[0] = 8'h01; exp[1] = 8'h02; exp[2] = 8'h03; exp[3] = 8'h04;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      checks++;
      if (fifo_cnt !== 3'd4 || overrun !== 1'b1) begin
         failures++; $display("FAIL ovr_state got c=%0d ovr=%b exp c=4 ovr=1", fifo_cnt, overrun);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rx_valid !== 1'b1 || rx_data !== exp[i]) begin
            failures++; $display("FAIL ovr_pop%0d got v=%b d=%h exp v=1 d=%h", i, rx_valid, rx_data, exp[i]);
         end
         do_pop();
      end
      checks++;
      if (rx_valid !== 1'b0) begin failures++; $display("FAIL ovr_empty got=%b exp=0", rx_valid); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clr got=%b exp=0", overrun); end
   endtask

   task automatic test_full_pop();
      logic [7:0] exp [4];
      exp[0] = 8'h11; exp[1] = 8'h12; exp[2] = 8'h13; exp[3] = 8'h77;
      for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
      // Frame of 0x77 with a one-cycle pop aligned to the stop-bit sample edge
      hold_bit(1'b0);
      for (int i = 0; i < 8; i++) hold_bit(1'(8'h77 >> i));
      rxd = 1'b1;
      repeat (6) tick();
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      checks++;
      if (fifo_cnt !== 3'd4 || overrun !== 1'b0) begin
         failures++; $display("FAIL full_pop_edge got c=%0d ovr=%b exp c=4 ovr=0", fifo_cnt, overrun);
      end
      tick();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rx_valid !== 1'b1 || rx_data !== exp[i]) begin
            failures++; $display("FAIL full_pop%0d got v=%b d=%h exp v=1 d=%h", i, rx_valid, rx_data, exp[i]);
         end
         do_pop();
      end
      checks++;
      if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
         failures++; $display("FAIL full_pop_end got v=%b ovr=%b exp v=0 ovr=0", rx_valid, overrun);
      end
   endtask

   task automatic test_reset_midframe();
      send_frame(8'hAA, 1'b1);
      hold_bit(1'b0);
      for (int i = 0; i < 4; i++) hold_bit(1'b0);
      io_resetb = 1'b0;
      #2;
      rxd = 1'b1;
      checks++;
      if (rx_valid !== 1'b0 || fifo_cnt !== 3'd0 || rx_data !== 8'h00) begin
         failures++;
         $display("FAIL rst_mid_async got v=%b c=%0d d=%h exp v=0 c=0 d=00", rx_valid, fifo_cnt, rx_data);
      end
      repeat (3) tick();
      io_resetb = 1'b1;
      repeat (4 * BAUD) tick();
      checks++;
      if (rx_valid !== 1'b0 || fifo_cnt !== 3'd0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_quiet got v=%b c=%0d fe=%b ovr=%b exp all 0", rx_valid, fifo_cnt, frame_err, overrun);
      end
      send_frame(8'h9E, 1'b1);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h9E || fifo_cnt !== 3'd1) begin
         failures++;
         $display("FAIL rst_mid_next got v=%b d=%h c=%0d exp v=1 d=9e c=1", rx_valid, rx_data, fifo_cnt);
      end
      do_pop();
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_glitch();
      test_framing();
      test_overrun();
      test_full_pop();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
